// File: rtl/serial_subtractor_ctrl.sv
// -----------------------------------------------------------------------------
// serial_subtractor_ctrl
//
// Bit-serial WIDTH-bit subtract controller. Computes A - B - Bin one bit per
// clock, LSB first, through a single full-subtractor slice. The running borrow
// lives in a flip-flop between cycles.
//
// Handshake: start is accepted in IDLE or DONE. busy is high while bits are
// processed, done pulses for one cycle when diff/bout have just been loaded.
// diff/bout (and ovf when enabled) hold the last result until the next
// operation completes.
//
// Optional feature macro: SERIAL_SUB_OVF_EN
//   When defined, adds output ovf = two's-complement signed overflow of the
//   subtraction, loaded and held together with diff/bout.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   operation request
//   a      in   minuend (WIDTH), captured on accepted start
//   b      in   subtrahend (WIDTH), captured on accepted start
//   bin    in   initial borrow-in, captured on accepted start
//   busy   out  high while bits are being processed
//   done   out  one-cycle pulse, result registers just updated
//   diff   out  registered difference (WIDTH)
//   bout   out  registered final borrow-out
//   ovf    out  registered signed overflow (only with SERIAL_SUB_OVF_EN)
// -----------------------------------------------------------------------------
module serial_subtractor_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-1:0] res_sh_reg;
    logic             borrow_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] diff_reg;
    logic             bout_reg;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf_reg;
`endif

    logic             accept;
    logic             last_bit;

    // Single full-subtractor slice operating on the current LSBs.
    logic             bit_x;
    logic             bit_y;
    logic             diff_bit;
    logic             borrow_next;

    assign bit_x       = a_sh_reg[0];
    assign bit_y       = b_sh_reg[0];
    assign diff_bit    = bit_x ^ bit_y ^ borrow_reg;
    assign borrow_next = (~bit_x & bit_y) | (~(bit_x ^ bit_y) & borrow_reg);

    assign last_bit    = (cnt_reg == CNT_LAST);

    // Right-shifted copies of the shift registers. The result register takes
    // the new difference bit at its MSB so that after WIDTH shifts bit 0 of the
    // operands has landed in bit 0 of the result.
    logic [WIDTH-1:0] a_sh_next;
    logic [WIDTH-1:0] b_sh_next;
    logic [WIDTH-1:0] res_sh_next;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
            assign a_sh_next[gi]   = a_sh_reg[gi+1];
            assign b_sh_next[gi]   = b_sh_reg[gi+1];
            assign res_sh_next[gi] = res_sh_reg[gi+1];
        end
    endgenerate

    assign a_sh_next[WIDTH-1]   = 1'b0;
    assign b_sh_next[WIDTH-1]   = 1'b0;
    assign res_sh_next[WIDTH-1] = diff_bit;

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next state and outputs
    // ---------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                // start is deliberately not looked at here.
                if (last_bit) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done = 1'b1;
                // A start arriving during the done pulse chains straight into
                // the next operation without an IDLE cycle.
                if (start) begin
                    accept     = 1'b1;
                    state_next = ST_RUN;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Datapath: operand/result shift registers, borrow flop, bit counter
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            res_sh_reg <= '0;
            borrow_reg <= 1'b0;
            cnt_reg    <= '0;
        end else if (accept) begin
            a_sh_reg   <= a;
            b_sh_reg   <= b;
            res_sh_reg <= '0;
            borrow_reg <= bin;
            cnt_reg    <= '0;
        end else if (busy) begin
            a_sh_reg   <= a_sh_next;
            b_sh_reg   <= b_sh_next;
            res_sh_reg <= res_sh_next;
            borrow_reg <= borrow_next;
            cnt_reg    <= cnt_reg + CNT_W'(1);
        end
    end

    // ---------------------------------------------------------------------
    // Result registers: loaded only on the edge that processes the MSB,
    // so the previous result stays visible for the whole run.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff_reg <= '0;
            bout_reg <= 1'b0;
        end else if (busy && last_bit) begin
            diff_reg <= res_sh_next;
            bout_reg <= borrow_next;
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    // Signed overflow: borrow into the MSB differs from borrow out of it.
    // On the final edge borrow_reg is the borrow into bit WIDTH-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_reg <= 1'b0;
        end else if (busy && last_bit) begin
            ovf_reg <= borrow_reg ^ borrow_next;
        end
    end

    assign ovf = ovf_reg;
`endif

    assign diff = diff_reg;
    assign bout = bout_reg;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for serial_subtractor_ctrl (WIDTH = 8).
// Expected results come from plain integer arithmetic on A - B - Bin.
// -----------------------------------------------------------------------------
module tb_serial_subtractor_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
`endif

    int checks;
    int errors;

    logic [WIDTH-1:0] exp_diff;
    logic             exp_bout;
    logic             exp_ovf;

    serial_subtractor_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: unsigned and signed integer arithmetic.
    function automatic void model(input logic [7:0] x, input logic [7:0] y, input logic bi,
                                  output logic [7:0] d, output logic bo, output logic ov);
        int r;
        int sx;
        int sy;
        int sr;
        r  = int'(x) - int'(y) - int'(bi);
        d  = r[7:0];
        bo = (r < 0);
        sx = (int'(x) > 127) ? int'(x) - 256 : int'(x);
        sy = (int'(y) > 127) ? int'(y) - 256 : int'(y);
        sr = sx - sy - int'(bi);
        ov = (sr < -128) || (sr > 127);
    endfunction

    // Present a request for edge 0; return at the negedge after edge 0 with
    // start dropped and inputs scrambled (capture must already have happened).
    task automatic issue(input logic [7:0] x, input logic [7:0] y, input logic bi);
        @(negedge clk);
        a     = x;
        b     = y;
        bin   = bi;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a     = 8'($urandom);
        b     = 8'($urandom);
        bin   = 1'($urandom);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'h00 || bout !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b diff=%h bout=%b, required 0 0 00 0",
                     busy, done, diff, bout);
        end
`ifdef SERIAL_SUB_OVF_EN
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf: ovf=%b, required 0", ovf);
        end
`endif
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b done=%b, required 0 0", busy, done);
        end
        exp_diff = '0;
        exp_bout = 1'b0;
        exp_ovf  = 1'b0;
        $display("reset: busy=%b done=%b diff=%h bout=%b", busy, done, diff, bout);
    endtask

    task automatic test_arith;
        logic [7:0] va[$];
        logic [7:0] vb[$];
        logic       vbin[$];
        logic [7:0] prev_diff;
        logic       prev_bout;
        int         cyc;
        int         busy_cnt;
        bit         held_ok;

        va.push_back(8'h05); vb.push_back(8'h03); vbin.push_back(1'b0);
        va.push_back(8'h03); vb.push_back(8'h05); vbin.push_back(1'b0);
        va.push_back(8'h00); vb.push_back(8'h00); vbin.push_back(1'b1);
        va.push_back(8'hFF); vb.push_back(8'hFF); vbin.push_back(1'b1);
        va.push_back(8'h80); vb.push_back(8'h01); vbin.push_back(1'b0);
        va.push_back(8'h10); vb.push_back(8'h01); vbin.push_back(1'b0);
        va.push_back(8'h7F); vb.push_back(8'hFF); vbin.push_back(1'b0);
        va.push_back(8'h00); vb.push_back(8'hFF); vbin.push_back(1'b1);
        for (int i = 0; i < 24; i++) begin
            va.push_back(8'($urandom));
            vb.push_back(8'($urandom));
            vbin.push_back(1'($urandom));
        end

        for (int i = 0; i < va.size(); i++) begin
            prev_diff = exp_diff;
            prev_bout = exp_bout;
            issue(va[i], vb[i], vbin[i]);
            model(va[i], vb[i], vbin[i], exp_diff, exp_bout, exp_ovf);
            cyc      = 0;
            busy_cnt = 0;
            held_ok  = 1'b1;
            while (done !== 1'b1 && cyc < 4 * WIDTH) begin
                if (busy === 1'b1) busy_cnt++;
                if (diff !== prev_diff || bout !== prev_bout) held_ok = 1'b0;
                @(negedge clk);
                cyc++;
            end
            $display("op a=%h b=%h bin=%b -> diff=%h bout=%b (exp %h %b) latency=%0d",
                     va[i], vb[i], vbin[i], diff, bout, exp_diff, exp_bout, cyc);
            checks++;
            if (done !== 1'b1 || cyc != WIDTH) begin
                errors++;
                $display("FAIL done_latency: done=%b after %0d cycles, required 1 after %0d",
                         done, cyc, WIDTH);
            end
            checks++;
            if (busy_cnt != WIDTH || busy !== 1'b0) begin
                errors++;
                $display("FAIL busy_width: busy high %0d cycles (busy at done=%b), required %0d (0)",
                         busy_cnt, busy, WIDTH);
            end
            checks++;
            if (!held_ok) begin
                errors++;
                $display("FAIL result_held: diff/bout changed during run, required %h/%b held",
                         prev_diff, prev_bout);
            end
            checks++;
            if (diff !== exp_diff || bout !== exp_bout) begin
                errors++;
                $display("FAIL result a=%h b=%h bin=%b: diff=%h bout=%b, required %h %b",
                         va[i], vb[i], vbin[i], diff, bout, exp_diff, exp_bout);
            end
`ifdef SERIAL_SUB_OVF_EN
            checks++;
            if (ovf !== exp_ovf) begin
                errors++;
                $display("FAIL ovf a=%h b=%h bin=%b: ovf=%b, required %b",
                         va[i], vb[i], vbin[i], ovf, exp_ovf);
            end
`endif
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL done_pulse_width: done=%b busy=%b one cycle later, required 0 0",
                         done, busy);
            end
        end
    endtask

    task automatic test_ignore_start;
        int         done_cnt;
        int         done_at;
        logic [7:0] diff_at;
        bit         restarted;
        logic       o;

        issue(8'h05, 8'h03, 1'b0);
        done_cnt  = 0;
        done_at   = -1;
        diff_at   = '0;
        restarted = 1'b0;
        for (int cyc = 0; cyc <= WIDTH + 6; cyc++) begin
            if (cyc == 2) begin
                start = 1'b1;
                a     = 8'hAA;
                b     = 8'h11;
            end
            if (cyc == 3) start = 1'b0;
            if (done === 1'b1) begin
                done_cnt++;
                done_at = cyc;
                diff_at = diff;
            end
            if (cyc > WIDTH && busy === 1'b1) restarted = 1'b1;
            @(negedge clk);
        end
        model(8'h05, 8'h03, 1'b0, exp_diff, exp_bout, o);
        exp_ovf = o;
        $display("ignore_start: done pulses=%0d at cycle %0d diff=%h", done_cnt, done_at, diff_at);
        checks++;
        if (done_cnt != 1 || done_at != WIDTH) begin
            errors++;
            $display("FAIL ignore_start_done: %0d pulses at %0d, required 1 at %0d",
                     done_cnt, done_at, WIDTH);
        end
        checks++;
        if (diff_at !== exp_diff || restarted) begin
            errors++;
            $display("FAIL ignore_start_result: diff=%h restarted=%b, required %h 0",
                     diff_at, restarted, exp_diff);
        end
    endtask

    task automatic test_back_to_back;
        int  cyc;
        bit  held_ok;
        logic o;

        @(negedge clk);
        a     = 8'h05;
        b     = 8'h03;
        bin   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a   = 8'h09;
        b   = 8'h04;
        cyc = 0;
        while (done !== 1'b1 && cyc < 4 * WIDTH) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (done !== 1'b1 || cyc != WIDTH || diff !== 8'h02) begin
            errors++;
            $display("FAIL b2b_first: done=%b at %0d diff=%h, required 1 at %0d diff 02",
                     done, cyc, diff, WIDTH);
        end
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_restart: busy=%b after done with start held, required 1", busy);
        end
        held_ok = 1'b1;
        while (done !== 1'b1 && cyc < 4 * WIDTH) begin
            if (diff !== 8'h02) held_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
        model(8'h09, 8'h04, 1'b0, exp_diff, exp_bout, o);
        exp_ovf = o;
        $display("back_to_back: second done %0d cycles after first, diff=%h bout=%b", cyc, diff, bout);
        checks++;
        if (!held_ok) begin
            errors++;
            $display("FAIL b2b_held: first result not held during second run, required 02");
        end
        checks++;
        if (done !== 1'b1 || cyc != WIDTH + 1 || diff !== exp_diff || bout !== exp_bout) begin
            errors++;
            $display("FAIL b2b_second: done=%b at %0d diff=%h bout=%b, required 1 at %0d %h %b",
                     done, cyc, diff, bout, WIDTH + 1, exp_diff, exp_bout);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midrun;
        bit   spurious;
        int   cyc;
        logic o;

        issue(8'h05, 8'h03, 1'b0);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        $display("reset_midrun: busy=%b done=%b diff=%h bout=%b", busy, done, diff, bout);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'h00 || bout !== 1'b0) begin
            errors++;
            $display("FAIL reset_midrun: busy=%b done=%b diff=%h bout=%b, required 0 0 00 0",
                     busy, done, diff, bout);
        end
`ifdef SERIAL_SUB_OVF_EN
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_midrun_ovf: ovf=%b, required 0", ovf);
        end
`endif
        @(negedge clk);
        rst_n    = 1'b1;
        spurious = 1'b0;
        for (int i = 0; i < 3 * WIDTH; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) spurious = 1'b1;
        end
        checks++;
        if (spurious) begin
            errors++;
            $display("FAIL reset_no_done: activity after reset without start, required idle");
        end
        issue(8'h07, 8'h02, 1'b0);
        model(8'h07, 8'h02, 1'b0, exp_diff, exp_bout, o);
        exp_ovf = o;
        cyc = 0;
        while (done !== 1'b1 && cyc < 4 * WIDTH) begin
            @(negedge clk);
            cyc++;
        end
        $display("after_reset op: diff=%h bout=%b latency=%0d", diff, bout, cyc);
        checks++;
        if (done !== 1'b1 || cyc != WIDTH || diff !== exp_diff || bout !== exp_bout) begin
            errors++;
            $display("FAIL after_reset_op: done=%b at %0d diff=%h bout=%b, required 1 at %0d %h %b",
                     done, cyc, diff, bout, WIDTH, exp_diff, exp_bout);
        end
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_arith();
        test_ignore_start();
        test_back_to_back();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
